// File: rtl/sc1_reset_pkg.sv
// ============================================================================
// Module      : sc1_reset_pkg
// Description : Shared FSM state encoding, reset-cause codes and a counter
//               sizing helper for the reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sc1_reset_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_WAIT    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_PORT   = 2'd0,
        CAUSE_BUTTON = 2'd1,
        CAUSE_LOCK   = 2'd2
    } cause_t;

    // Bits needed for a counter that takes the values 0 .. terminal-1.
    function automatic int unsigned cnt_width(input int unsigned terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sequencer_sync_debounce.sv
// ============================================================================
// Module      : sync_debounce
// Description : Multi-flop synchroniser followed by an optional debounce
//               filter; DEBOUNCE_CYCLES = 0 gives a plain synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_debounce
    import sc1_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter bit          RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   w_sync;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
    assign w_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    if (DEBOUNCE_CYCLES > 0) begin : g_debounce
        localparam int unsigned c_cnt_w = cnt_width(DEBOUNCE_CYCLES);
        localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

        logic               deb_q;
        logic               deb_d;
        logic [c_cnt_w-1:0] cnt_q;
        logic [c_cnt_w-1:0] cnt_d;

        // Any sample equal to the filtered level restarts the run length.
        always_comb begin
            deb_d = deb_q;
            cnt_d = '0;
            if (w_sync != deb_q) begin
                if (cnt_q == c_cnt_last) begin
                    deb_d = w_sync;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                deb_q <= RESET_LEVEL;
                cnt_q <= '0;
            end else begin
                deb_q <= deb_d;
                cnt_q <= cnt_d;
            end
        end

        assign dout = deb_q;
    end else begin : g_passthrough
        assign dout = w_sync;
    end

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module      : reset_sequencer
// Description : Power-on / button / PLL-lock reset sequencer with staggered
//               release of NUM_OUT synchronous reset domains.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer
    import sc1_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 65536,
    parameter int unsigned HOLD_CYCLES       = 16,
    parameter int unsigned NUM_OUT           = 2,
    parameter int unsigned STAGGER           = 4,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               button_in,
    input  logic               pll_locked,
    output logic [NUM_OUT-1:0] reset_out,
    output logic               ready,
    output logic [1:0]         cause
);

    localparam int unsigned c_release_last = (NUM_OUT - 1) * STAGGER;
    localparam int unsigned c_cnt_span     = (HOLD_CYCLES > c_release_last) ?
                                             HOLD_CYCLES : c_release_last;
    localparam int unsigned c_cnt_w        = cnt_width(c_cnt_span);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);

    logic w_button_db;
    logic w_lock_ok;
    logic w_pressed;
    logic w_abort;

    // The filtered button starts at its released level.
    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (BUTTON_ACTIVE_LOW)
    ) u_button (
        .clk   (clk),
        .reset (reset),
        .din   (button_in),
        .dout  (w_button_db)
    );

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (0),
        .RESET_LEVEL     (1'b0)
    ) u_lock (
        .clk   (clk),
        .reset (reset),
        .din   (pll_locked),
        .dout  (w_lock_ok)
    );

    assign w_pressed = BUTTON_ACTIVE_LOW ? ~w_button_db : w_button_db;
    assign w_abort   = w_pressed | ~w_lock_ok;

    state_t               state_q,     state_d;
    cause_t               cause_q,     cause_d;
    logic [c_cnt_w-1:0]   cnt_q,       cnt_d;
    logic [NUM_OUT-1:0]   reset_out_q, reset_out_d;
    logic                 ready_q,     ready_d;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_ASSERT: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (w_lock_ok && !w_pressed) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == c_hold_last) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + c_cnt_w'(1);
                end
            end
            ST_RELEASE: begin
                // RUN coincides with the last domain's release; a single
                // domain still spends one cycle in RELEASE.
                if (32'(cnt_q) + 32'd1 >= c_release_last) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + c_cnt_w'(1);
                end
            end
            ST_RUN: begin
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
            end
        endcase

        if (w_abort && (state_q == ST_HOLD || state_q == ST_RELEASE ||
                        state_q == ST_RUN)) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            cause_d = w_lock_ok ? CAUSE_BUTTON : CAUSE_LOCK;
        end
    end

    // Outputs are decoded from the next state so they switch with it,
    // straight from flops.
    always_comb begin
        reset_out_d = '1;
        ready_d     = (state_d == ST_RUN);
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            reset_out_d[i] = !((state_d == ST_RUN) ||
                               ((state_d == ST_RELEASE) &&
                                (32'(cnt_d) >= i * STAGGER)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ASSERT;
            cause_q     <= CAUSE_PORT;
            cnt_q       <= '0;
            reset_out_q <= '1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            cnt_q       <= cnt_d;
            reset_out_q <= reset_out_d;
            ready_q     <= ready_d;
        end
    end

    assign reset_out = reset_out_q;
    assign ready     = ready_q;
    assign cause     = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Directed, table-driven bench for reset_sequencer with
//               NUM_OUT = 2, 1 and 4 instances sharing one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       button_in;
    logic       pll_locked;
    logic [1:0] rst2;
    logic       rdy2;
    logic [1:0] cause2;
    logic [0:0] rst1;
    logic       rdy1;
    logic [1:0] cause1;
    logic [3:0] rst4;
    logic       rdy4;
    logic [1:0] cause4;

    reset_sequencer #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(16),
        .NUM_OUT(2), .STAGGER(4), .BUTTON_ACTIVE_LOW(1'b1)
    ) dut2 (
        .clk(clk), .reset(reset), .button_in(button_in), .pll_locked(pll_locked),
        .reset_out(rst2), .ready(rdy2), .cause(cause2)
    );

    reset_sequencer #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(16),
        .NUM_OUT(1), .STAGGER(4), .BUTTON_ACTIVE_LOW(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset), .button_in(button_in), .pll_locked(pll_locked),
        .reset_out(rst1), .ready(rdy1), .cause(cause1)
    );

    reset_sequencer #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(16),
        .NUM_OUT(4), .STAGGER(1), .BUTTON_ACTIVE_LOW(1'b1)
    ) dut4 (
        .clk(clk), .reset(reset), .button_in(button_in), .pll_locked(pll_locked),
        .reset_out(rst4), .ready(rdy4), .cause(cause4)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int rel);
        while (cyc - base < rel) step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at rel cycle %0d: got %0h expected %0h", name, cyc - base, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic [1:0] e_rst,
                              input logic e_rdy, input logic [1:0] e_cause);
        check({tag, ".reset_out"}, 32'(rst2), 32'(e_rst));
        check({tag, ".ready"},     32'(rdy2), 32'(e_rdy));
        check({tag, ".cause"},     32'(cause2), 32'(e_cause));
    endtask

    typedef struct {
        int         rel;
        logic       rst_in;
        logic       btn;
        logic       lock;
        logic [1:0] e_out2;
        logic       e_rdy2;
        logic [1:0] e_cause2;
        logic       e_out1;
        logic       e_rdy1;
        logic [3:0] e_out4;
        logic       e_rdy4;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // Start-up from the reset port: HOLD at 3, RELEASE at 19.
        tbl[0]  = '{0,  1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'd0, 1'b1, 1'b0, 4'b1111, 1'b0};
        tbl[1]  = '{1,  1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'd0, 1'b1, 1'b0, 4'b1111, 1'b0};
        tbl[2]  = '{2,  1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'd0, 1'b1, 1'b0, 4'b1111, 1'b0};
        tbl[3]  = '{3,  1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'd0, 1'b1, 1'b0, 4'b1111, 1'b0};
        tbl[4]  = '{18, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'd0, 1'b1, 1'b0, 4'b1111, 1'b0};
        tbl[5]  = '{19, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1110, 1'b0};
        tbl[6]  = '{20, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1100, 1'b0};
        tbl[7]  = '{21, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1000, 1'b0};
        tbl[8]  = '{22, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1};
        tbl[9]  = '{23, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1};
        tbl[10] = '{30, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1};

        reset      = 1'b1;
        button_in  = 1'b1;
        pll_locked = 1'b1;
        repeat (3) step();
        base = cyc;

        for (int k = 0; k < 11; k++) begin
            run_to(tbl[k].rel);
            reset      = tbl[k].rst_in;
            button_in  = tbl[k].btn;
            pll_locked = tbl[k].lock;
            check_main($sformatf("startup[%0d]", tbl[k].rel),
                       tbl[k].e_out2, tbl[k].e_rdy2, tbl[k].e_cause2);
            check("startup.n1.reset_out", 32'(rst1), 32'(tbl[k].e_out1));
            check("startup.n1.ready",     32'(rdy1), 32'(tbl[k].e_rdy1));
            check("startup.n4.reset_out", 32'(rst4), 32'(tbl[k].e_out4));
            check("startup.n4.ready",     32'(rdy4), 32'(tbl[k].e_rdy4));
        end

        // One-cycle lock loss in RUN, then automatic restart.
        base = cyc;
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        check_main("lockloss.t1", 2'b00, 1'b1, 2'd0);
        run_to(2);  check_main("lockloss.t2", 2'b00, 1'b1, 2'd0);
        run_to(3);  check_main("lockloss.assert", 2'b11, 1'b0, 2'd2);
        run_to(20); check_main("lockloss.hold", 2'b11, 1'b0, 2'd2);
        run_to(21); check_main("lockloss.rel0", 2'b10, 1'b0, 2'd2);
        run_to(24); check_main("lockloss.rel3", 2'b10, 1'b0, 2'd2);
        check("lockloss.n4.ready", 32'(rdy4), 32'd1);
        run_to(25); check_main("lockloss.run", 2'b00, 1'b1, 2'd2);

        // Button: a 5-cycle bounce is ignored, a held press resets.
        run_to(30);
        base = cyc;
        button_in = 1'b0;
        run_to(5);
        button_in = 1'b1;
        run_to(20); check_main("bounce.ignored", 2'b00, 1'b1, 2'd2);
        base = cyc;
        button_in = 1'b0;
        run_to(10); check_main("press.pre", 2'b00, 1'b1, 2'd2);
        run_to(11); check_main("press.assert", 2'b11, 1'b0, 2'd1);
        run_to(12);
        button_in = 1'b1;
        run_to(22); check_main("press.wait", 2'b11, 1'b0, 2'd1);
        run_to(38); check_main("press.hold", 2'b11, 1'b0, 2'd1);
        run_to(39); check_main("press.rel0", 2'b10, 1'b0, 2'd1);
        run_to(43); check_main("press.run", 2'b00, 1'b1, 2'd1);

        // Reset port in RUN, then press and lock loss together in RELEASE.
        run_to(50);
        base = cyc;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_main("portreset.run", 2'b11, 1'b0, 2'd0);
        base = cyc;
        run_to(10); button_in  = 1'b0;
        run_to(18); pll_locked = 1'b0;
        run_to(19); pll_locked = 1'b1;
        check_main("both.rel0", 2'b10, 1'b0, 2'd0);
        run_to(20); check_main("both.rel1", 2'b10, 1'b0, 2'd0);
        run_to(21); check_main("both.assert", 2'b11, 1'b0, 2'd2);
        button_in = 1'b1;

        // Restart, then the reset port pulsed after reset_out[0] has fallen.
        run_to(47); check_main("restart.hold", 2'b11, 1'b0, 2'd2);
        run_to(48); check_main("restart.rel0", 2'b10, 1'b0, 2'd2);
        run_to(49);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_main("relreset.abort", 2'b11, 1'b0, 2'd0);
        base = cyc;
        run_to(19); check_main("relreset.rel0", 2'b10, 1'b0, 2'd0);
        run_to(23); check_main("relreset.run", 2'b00, 1'b1, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flop count of each input synchroniser, minimum 2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 65536: cycles button_in must be stable before its debounced state changes.
REQ-003 Parameter HOLD_CYCLES, default 16: cycles all outputs stay asserted after the start conditions are met.
REQ-004 Parameter NUM_OUT, default 2: number of independent reset outputs (domains).
REQ-005 Parameter STAGGER, default 4: cycles between the releases of successive outputs.
REQ-006 Parameter BUTTON_ACTIVE_LOW, default 1: 1 = button_in low means pressed.
REQ-007 clk  input  1  sole clock; all logic on its rising edge.
REQ-008 reset  input  1  reset is synchronous and active-high.
REQ-009 button_in  input  1  asynchronous push-button level.
REQ-010 pll_locked  input  1  asynchronous PLL lock indication.
REQ-011 reset_out  output  NUM_OUT  active-high synchronous resets; bit 0 is released first.
REQ-012 ready  output  1  high only in RUN.
REQ-013 cause  output  2  last reset cause: 0 = reset port, 1 = button, 2 = lock loss.

Function
REQ-014 button_in and pll_locked SHALL each pass through a SYNC_STAGES flop chain before any use.
REQ-015 The debounced button state SHALL change only after the synchronised button has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count at 0.
REQ-016 Lock loss SHALL NOT be debounced: synchronised pll_locked = 0 acts on the next edge.
REQ-017 The FSM SHALL have states ASSERT, WAIT, HOLD, RELEASE and RUN.
REQ-018 ASSERT: all reset_out = 1 and ready = 0; the FSM goes to WAIT after exactly 1 cycle.
REQ-019 WAIT: the FSM goes to HOLD on the first cycle in which synchronised lock = 1 and the debounced button = released.
REQ-020 HOLD: a counter runs from 0 to HOLD_CYCLES-1; the FSM goes to RELEASE after exactly HOLD_CYCLES cycles.
REQ-021 RELEASE: reset_out[i] SHALL fall i*STAGGER cycles after RELEASE entry and stay low.
REQ-022 The FSM SHALL enter RUN in the same cycle that reset_out[NUM_OUT-1] falls; ready rises in that cycle.
REQ-023 If NUM_OUT = 1, RELEASE SHALL last 1 cycle.
REQ-024 In HOLD, RELEASE or RUN, a debounced press or synchronised lock = 0 SHALL force ASSERT on the next edge, with all reset_out = 1 and ready = 0 in that cycle.
REQ-025 A press or lock loss in WAIT SHALL keep the FSM in WAIT.
REQ-026 cause SHALL update on entry to ASSERT; if press and lock loss occur in the same cycle, cause = 2.
REQ-027 Holding the button keeps the FSM in WAIT; release SHALL be honoured only after DEBOUNCE_CYCLES stable cycles.
REQ-028 All counters SHALL be sized with $clog2 of their terminal value and SHALL saturate, never wrap.

Reset
REQ-029 When reset = 1, the block SHALL enter the following state: FSM = ASSERT, reset_out = all 1, ready = 0, cause = 0, synchroniser flops = 0, debounced button = released, all counters = 0.
REQ-030 Asserting reset mid-sequence, including in RUN, SHALL abort the sequence with the same values on the next edge.

Structure
REQ-031 The FSM state encoding and cause codes SHALL reside in a shared package, sc1_reset_pkg.
REQ-032 Synchronisation plus debounce SHALL be one sub-module, sync_debounce, instantiated once per filtered input; lock uses it with debounce disabled.

Verification (defaults: SYNC_STAGES=2, HOLD_CYCLES=16, NUM_OUT=2, STAGGER=4; DEBOUNCE_CYCLES=8 on the bench)
REQ-033 Lock high and button released, reset deasserted at cycle 0 -> HOLD entered at cycle 3, reset_out[0] falls at cycle 19, reset_out[1] and ready at cycle 23, cause = 0.
REQ-034 In RUN, pll_locked low for 1 cycle -> ASSERT 3 cycles later, cause = 2, full sequence repeats once lock is seen high.
REQ-035 In RUN, button pulses of 5 cycles -> no effect; a press held 8 cycles -> ASSERT, cause = 1; release held 8 cycles -> sequence restarts.
REQ-036 Press and lock loss arriving in the same cycle in RELEASE -> ASSERT, cause = 2, reset_out = 2'b11.
REQ-037 reset pulsed during RELEASE (after reset_out[0] falls) -> next edge reset_out = 2'b11, ready = 0, cause = 0.
REQ-038 Parameter sweep NUM_OUT=1 and NUM_OUT=4 with STAGGER=1 -> release spacing and ready timing per REQ-021 to REQ-023.
